// File: rtl/etroc2_phaseshift_pkg.sv
// Shared definitions for the multi-channel 40 MHz phase shifter.
//   - default parameter values (phase width, align load, lock/watchdog limits)
//   - lock FSM state encoding
//   - ch_field(): pulls channel k's pb-bit field out of a packed per-channel bus
package etroc2_phaseshift_pkg;

    localparam int DEF_PB         = 5;
    localparam int DEF_ALIGN_LOAD = 3;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_WDOG_LIMIT = 64;

    // Widest packed configuration bus the field extractor handles (NCH*PB).
    localparam int MAX_BUS = 512;
    localparam int FIELD_W = 32;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    // Channel k occupies bits [k*pb +: pb]; result is right-aligned and zero-filled.
    function automatic logic [FIELD_W-1:0] ch_field(input logic [MAX_BUS-1:0] bus,
                                                    input int k,
                                                    input int pb);
        logic [MAX_BUS-1:0] mask;
        mask = (MAX_BUS'(1) << pb) - MAX_BUS'(1);
        return FIELD_W'((bus >> (k * pb)) & mask);
    endfunction

endpackage

// File: rtl/phase_pulse_gen.sv
// One output channel of the phase shifter.
// Holds shadowed delay/width, compares them against the shared phase counter
// and registers the (enabled, optionally inverted) pulse.
// Ports:
//   i_clk1280  fast clock
//   i_rstn     synchronous active-low reset
//   i_phase    current phase counter value
//   i_load     copy i_delay/i_width into the shadows this cycle
//   i_delay    requested rising phase
//   i_width    requested high width
//   i_enable   channel enable (applied directly)
//   i_invert   output inversion (applied directly)
//   o_clkout   registered channel clock
module phase_pulse_gen
    import etroc2_phaseshift_pkg::*;
#(
    parameter int PB = DEF_PB
) (
    input  logic          i_clk1280,
    input  logic          i_rstn,
    input  logic [PB-1:0] i_phase,
    input  logic          i_load,
    input  logic [PB-1:0] i_delay,
    input  logic [PB-1:0] i_width,
    input  logic          i_enable,
    input  logic          i_invert,
    output logic          o_clkout
);

    localparam logic [PB-1:0] HALF = PB'(1) << (PB - 1);

    logic [PB-1:0] r_delay;
    logic [PB-1:0] r_width;
    logic [PB-1:0] w_fall;
    logic          w_pulse;
    logic          r_clkout;

    assign w_fall = r_delay + r_width;

    // Zero width degenerates to a single-count pulse; a falling edge below the
    // rising edge means the high window wraps through count 0.
    always_comb begin
        w_pulse = 1'b0;
        if (w_fall > r_delay) begin
            w_pulse = (i_phase >= r_delay) && (i_phase < w_fall);
        end else if (w_fall == r_delay) begin
            w_pulse = (i_phase == r_delay);
        end else begin
            w_pulse = !((i_phase >= w_fall) && (i_phase < r_delay));
        end
    end

    always_ff @(posedge i_clk1280) begin
        if (!i_rstn) begin
            r_delay  <= '0;
            r_width  <= HALF;
            r_clkout <= 1'b0;
        end else begin
            if (i_load) begin
                r_delay <= i_delay;
                r_width <= i_width;
            end
            r_clkout <= (i_enable & w_pulse) ^ i_invert;
        end
    end

    assign o_clkout = r_clkout;

endmodule

// File: rtl/digital_phaseshifter_multi.sv
// N-channel phase shifter for the readout clock tree.
// Samples clk40 as data, aligns a PB-bit phase counter to its rising edge,
// tracks alignment lock and drives one phase_pulse_gen per channel.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   UNLOCKED  | no reference seen yet or watchdog expired; shadows follow inputs
//   ACQUIRE   | edges seen, counting consecutive consistent edges
//   LOCKED    | LOCK_COUNT consistent edges seen; o_locked high
//
// Ports:
//   i_clk1280     fast clock, the only clock
//   i_rstn        synchronous active-low reset
//   i_clk40       40 MHz reference, asynchronous data
//   i_chEnable    per-channel enable
//   i_chInvert    per-channel output inversion
//   i_clockDelay  per-channel rising phase, channel k at [k*PB +: PB]
//   i_pulseWidth  per-channel high width, same packing
//   o_clkout      generated clocks
//   o_phaseCount  phase counter (debug)
//   o_locked      alignment locked
//   o_alignErr    one-cycle pulse on misaligned or missing reference edge
module digital_phaseshifter_multi
    import etroc2_phaseshift_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int PB         = DEF_PB,
    parameter int ALIGN_LOAD = DEF_ALIGN_LOAD,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic              i_clk1280,
    input  logic              i_rstn,
    input  logic              i_clk40,
    input  logic [NCH-1:0]    i_chEnable,
    input  logic [NCH-1:0]    i_chInvert,
    input  logic [NCH*PB-1:0] i_clockDelay,
    input  logic [NCH*PB-1:0] i_pulseWidth,
    output logic [NCH-1:0]    o_clkout,
    output logic [PB-1:0]     o_phaseCount,
    output logic              o_locked,
    output logic              o_alignErr
);

    localparam int              WDW      = $clog2(WDOG_LIMIT + 1);
    localparam logic [PB-1:0]   LOAD_VAL = PB'(ALIGN_LOAD);
    localparam logic [PB-1:0]   PH_MAX   = '1;
    localparam logic [WDW-1:0]  WDOG_TC  = WDW'(WDOG_LIMIT);
    localparam logic [3:0]      GOOD_TC  = 4'(LOCK_COUNT);

    logic          r_sync;
    logic          r_d1;
    logic          r_d2;
    logic [PB-1:0] r_phase;
    logic [PB-1:0] w_phase_inc;
    logic          w_rise;
    logic          w_consistent;
    logic          w_shadow_load;

    lock_state_t   r_state;
    lock_state_t   w_state_nxt;
    logic [3:0]    r_good;
    logic [3:0]    w_good_nxt;
    logic [3:0]    w_good_inc;
    logic [WDW-1:0] r_wdog;
    logic [WDW-1:0] w_wdog_nxt;
    logic [WDW-1:0] w_wdog_inc;
    logic          r_locked;
    logic          r_align_err;
    logic          w_err;

    assign w_rise       = r_d1 & ~r_d2;
    assign w_phase_inc  = r_phase + PB'(1);
    // The edge is consistent when it reloads the value the counter would reach anyway.
    assign w_consistent = w_rise && (w_phase_inc == LOAD_VAL);
    assign w_good_inc   = r_good + 4'd1;
    assign w_wdog_inc   = r_wdog + WDW'(1);

    // Shadows load on the last count of a period so the new setting starts at count 0.
    assign w_shadow_load = (r_phase == PH_MAX) || (r_state == ST_UNLOCKED);

    always_ff @(posedge i_clk1280) begin
        if (!i_rstn) begin
            r_sync      <= 1'b0;
            r_d1        <= 1'b0;
            r_d2        <= 1'b0;
            r_phase     <= '0;
            r_state     <= ST_UNLOCKED;
            r_good      <= '0;
            r_wdog      <= '0;
            r_locked    <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_sync      <= i_clk40;
            r_d1        <= r_sync;
            r_d2        <= r_d1;
            r_phase     <= w_rise ? LOAD_VAL : w_phase_inc;
            r_state     <= w_state_nxt;
            r_good      <= w_good_nxt;
            r_wdog      <= w_wdog_nxt;
            r_locked    <= (w_state_nxt == ST_LOCKED);
            r_align_err <= w_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_wdog_nxt  = w_rise ? '0 : w_wdog_inc;
        w_err       = 1'b0;

        case (r_state)
            ST_UNLOCKED: begin
                w_wdog_nxt = '0;
                if (w_rise) begin
                    w_good_nxt  = 4'd1;
                    w_state_nxt = (GOOD_TC <= 4'd1) ? ST_LOCKED : ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (w_consistent) begin
                    w_good_nxt = w_good_inc;
                    if (w_good_inc >= GOOD_TC) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end else if (w_rise) begin
                    w_good_nxt = 4'd1;
                    w_err      = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_rise && !w_consistent) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = 4'd1;
                    w_err       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
                w_wdog_nxt  = '0;
            end
        endcase

        // A rise in the expiry cycle has already cleared the watchdog and wins.
        if ((r_state != ST_UNLOCKED) && !w_rise && (w_wdog_inc == WDOG_TC)) begin
            w_state_nxt = ST_UNLOCKED;
            w_wdog_nxt  = '0;
            w_err       = 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [PB-1:0] w_delay;
        logic [PB-1:0] w_width;

        assign w_delay = PB'(ch_field(MAX_BUS'(i_clockDelay), k, PB));
        assign w_width = PB'(ch_field(MAX_BUS'(i_pulseWidth), k, PB));

        phase_pulse_gen #(
            .PB(PB)
        ) u_pulse (
            .i_clk1280 (i_clk1280),
            .i_rstn    (i_rstn),
            .i_phase   (r_phase),
            .i_load    (w_shadow_load),
            .i_delay   (w_delay),
            .i_width   (w_width),
            .i_enable  (i_chEnable[k]),
            .i_invert  (i_chInvert[k]),
            .o_clkout  (o_clkout[k])
        );
    end

    assign o_phaseCount = r_phase;
    assign o_locked     = r_locked;
    assign o_alignErr   = r_align_err;

endmodule

// File: tb/tb_digital_phaseshifter_multi.sv
// Directed bench for digital_phaseshifter_multi (NCH=4, PB=5).
// clk40 is produced from a bench counter k (0..31, high for k<16). The edge
// taken while k==j gives phaseCount j+1 once aligned, and clkout reflects
// the pulse at count j.
module tb_digital_phaseshifter_multi;

    localparam int NCH = 4;
    localparam int PB  = 5;
    localparam int NPH = 32;

    logic              clk1280 = 1'b0;
    logic              rstn    = 1'b0;
    logic              clk40   = 1'b0;
    logic [NCH-1:0]    ch_en   = '0;
    logic [NCH-1:0]    ch_inv  = '0;
    logic [NCH*PB-1:0] dly_bus = '0;
    logic [NCH*PB-1:0] wid_bus = '0;
    logic [NCH-1:0]    clkout;
    logic [PB-1:0]     phase;
    logic              locked;
    logic              align_err;

    int checks   = 0;
    int failures = 0;
    int k        = 31;
    int k_edge   = 0;
    int hold     = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    bit run      = 1'b0;
    int act_dly[NCH];
    int act_wid[NCH];

    digital_phaseshifter_multi #(.NCH(NCH), .PB(PB)) dut (
        .i_clk1280    (clk1280),
        .i_rstn       (rstn),
        .i_clk40      (clk40),
        .i_chEnable   (ch_en),
        .i_chInvert   (ch_inv),
        .i_clockDelay (dly_bus),
        .i_pulseWidth (wid_bus),
        .o_clkout     (clkout),
        .o_phaseCount (phase),
        .o_locked     (locked),
        .o_alignErr   (align_err)
    );

    always #5 clk1280 = ~clk1280;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk1280);
        k_edge = k;
        #1;
        cyc++;
        if (run && k_edge == 2) rise_cyc = cyc;
        if (hold > 0) hold--;
        else k = (k + 1) % NPH;
        clk40 = run && (k < NPH / 2);
    endtask

    task automatic set_ch(input int c, input int d, input int w);
        dly_bus[c*PB +: PB] = PB'(d);
        wid_bus[c*PB +: PB] = PB'(w);
        act_dly[c] = d;
        act_wid[c] = w;
    endtask

    // Expected clkout for count p, using the configuration the shadows should hold.
    function automatic logic [NCH-1:0] exp_clk(input int p);
        logic [NCH-1:0] v;
        int  off;
        bit  pl;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            off = (p - act_dly[c] + NPH) % NPH;
            pl  = (act_wid[c] == 0) ? (p == act_dly[c]) : (off < act_wid[c]);
            v[c] = (ch_en[c] & pl) ^ ch_inv[c];
        end
        return v;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        run  = 1'b0;
        ch_en  = 4'b0111;
        ch_inv = 4'b0000;
        set_ch(0, 0, 16);
        set_ch(1, 28, 8);
        set_ch(2, 5, 0);
        set_ch(3, 0, 16);
        repeat (3) step();
        checks++;
        if (phase !== '0) begin
            failures++; $display("FAIL reset_phase: got %0d expected 0", phase);
        end
        checks++;
        if (clkout !== '0) begin
            failures++; $display("FAIL reset_clkout: got %b expected 0000", clkout);
        end
        checks++;
        if (locked !== 1'b0 || align_err !== 1'b0) begin
            failures++; $display("FAIL reset_status: got locked=%b err=%b expected 0 0", locked, align_err);
        end
        rstn = 1'b1;
    endtask

    task automatic test_lock_acquire();
        int rises = 0;
        bit err_seen = 1'b0;
        bit done = 1'b0;
        k   = 31;
        run = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (align_err === 1'b1) err_seen = 1'b1;
            if (k_edge == 1 && rises == 3) begin
                checks++;
                if (locked !== 1'b0) begin
                    failures++; $display("FAIL lock_early: got locked=%b expected 0", locked);
                end
            end
            if (k_edge == 2) begin
                rises++;
                if (rises == 4) begin
                    checks++;
                    if (locked !== 1'b1) begin
                        failures++; $display("FAIL lock_after_4: got locked=%b expected 1", locked);
                    end
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            checks++; failures++; $display("FAIL lock_timeout: got no 4th edge expected lock");
        end
        checks++;
        if (err_seen) begin
            failures++; $display("FAIL lock_spurious_err: got alignErr=1 expected 0");
        end
    endtask

    task automatic test_patterns();
        int hi0 = 0, hi1 = 0, hi2 = 0;
        for (int i = 0; i < 64 && k_edge != 31; i++) step();
        for (int i = 0; i < NPH; i++) begin
            step();
            checks++;
            if (phase !== PB'((k_edge + 1) % NPH)) begin
                failures++; $display("FAIL pat_phase@%0d: got %0d expected %0d", k_edge, phase, (k_edge + 1) % NPH);
            end
            checks++;
            if (clkout !== exp_clk(k_edge)) begin
                failures++; $display("FAIL pat_clkout@%0d: got %b expected %b", k_edge, clkout, exp_clk(k_edge));
            end
            hi0 += int'(clkout[0]);
            hi1 += int'(clkout[1]);
            hi2 += int'(clkout[2]);
        end
        checks++;
        if (hi0 != 16 || hi1 != 8 || hi2 != 1) begin
            failures++; $display("FAIL pat_high_counts: got %0d/%0d/%0d expected 16/8/1", hi0, hi1, hi2);
        end
    endtask

    task automatic test_shadow_update();
        int  edges = 0;
        logic prev;
        for (int i = 0; i < 64 && k_edge != 11; i++) step();
        checks++;
        if (phase !== PB'(12)) begin
            failures++; $display("FAIL shadow_start_phase: got %0d expected 12", phase);
        end
        prev = clkout[0];
        dly_bus[0 +: PB] = PB'(10);
        for (int i = 0; i < 52; i++) begin
            step();
            checks++;
            if (clkout !== exp_clk(k_edge)) begin
                failures++; $display("FAIL shadow_clkout@%0d: got %b expected %b", k_edge, clkout, exp_clk(k_edge));
            end
            if (clkout[0] && !prev) edges++;
            prev = clkout[0];
            if (k_edge == 31) act_dly[0] = 10;
        end
        checks++;
        if (edges != 1) begin
            failures++; $display("FAIL shadow_edges: got %0d rising edges expected 1", edges);
        end
    endtask

    task automatic test_phase_shift();
        int  rises = 0;
        bit  done = 1'b0;
        for (int i = 0; i < 64 && k_edge != 19; i++) step();
        hold = 3;
        for (int i = 0; i < 80 && k_edge != 2; i++) begin
            step();
            if (k_edge == 1) begin
                checks++;
                if (locked !== 1'b1 || align_err !== 1'b0) begin
                    failures++; $display("FAIL shift_pre: got locked=%b err=%b expected 1 0", locked, align_err);
                end
            end
        end
        checks++;
        if (align_err !== 1'b1 || locked !== 1'b0) begin
            failures++; $display("FAIL shift_err: got err=%b locked=%b expected 1 0", align_err, locked);
        end
        step();
        checks++;
        if (align_err !== 1'b0) begin
            failures++; $display("FAIL shift_err_width: got err=%b expected 0", align_err);
        end
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (k_edge == 1 && rises == 2) begin
                checks++;
                if (locked !== 1'b0) begin
                    failures++; $display("FAIL relock_early: got locked=%b expected 0", locked);
                end
            end
            if (k_edge == 2) begin
                rises++;
                if (rises == 3) begin
                    checks++;
                    if (locked !== 1'b1) begin
                        failures++; $display("FAIL relock: got locked=%b expected 1", locked);
                    end
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            checks++; failures++; $display("FAIL relock_timeout: got no relock expected lock");
        end
        for (int i = 0; i < NPH; i++) begin
            step();
            checks++;
            if (phase !== PB'((k_edge + 1) % NPH) || clkout !== exp_clk(k_edge)) begin
                failures++;
                $display("FAIL shift_reref@%0d: got phase=%0d clk=%b expected phase=%0d clk=%b",
                         k_edge, phase, clkout, (k_edge + 1) % NPH, exp_clk(k_edge));
            end
        end
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 64 && k_edge != 20; i++) step();
        run = 1'b0;
        for (int i = 0; i < 100 && cyc < rise_cyc + 63; i++) step();
        checks++;
        if (align_err !== 1'b0 || locked !== 1'b1) begin
            failures++; $display("FAIL wdog_pre: got err=%b locked=%b expected 0 1", align_err, locked);
        end
        step();
        checks++;
        if (align_err !== 1'b1 || locked !== 1'b0) begin
            failures++; $display("FAIL wdog_expire: got err=%b locked=%b expected 1 0", align_err, locked);
        end
        step();
        checks++;
        if (align_err !== 1'b0) begin
            failures++; $display("FAIL wdog_err_width: got err=%b expected 0", align_err);
        end
        for (int i = 0; i < NPH; i++) begin
            step();
            checks++;
            if (phase !== PB'((k_edge + 1) % NPH) || clkout !== exp_clk(k_edge)) begin
                failures++;
                $display("FAIL wdog_freerun@%0d: got phase=%0d clk=%b expected phase=%0d clk=%b",
                         k_edge, phase, clkout, (k_edge + 1) % NPH, exp_clk(k_edge));
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int  rises = 0;
        ch_en  = 4'b1001;
        ch_inv = 4'b1010;
        set_ch(0, 0, 16);
        set_ch(3, 20, 4);
        for (int i = 0; i < 64 && k_edge != 20; i++) step();
        run = 1'b1;
        for (int i = 0; i < 200 && rises < 4; i++) begin
            step();
            if (k_edge == 2) rises++;
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL rst_prelock: got locked=%b expected 1", locked);
        end
        for (int i = 0; i < 64 && k_edge != 8; i++) step();
        checks++;
        if (clkout !== exp_clk(8) || clkout[0] !== 1'b1) begin
            failures++; $display("FAIL rst_midpulse: got %b expected %b", clkout, exp_clk(8));
        end
        rstn = 1'b0;
        run  = 1'b0;
        step();
        checks++;
        if (clkout !== '0 || locked !== 1'b0 || phase !== '0 || align_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_edge: got clk=%b locked=%b phase=%0d err=%b expected 0000 0 0 0",
                     clkout, locked, phase, align_err);
        end
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (clkout !== 4'b0011) begin
            failures++; $display("FAIL rst_release: got %b expected 0011", clkout);
        end
        for (int j = 1; j <= 10; j++) begin
            step();
            checks++;
            if (clkout !== 4'b1011 || phase !== PB'(j + 1)) begin
                failures++; $display("FAIL rst_after@%0d: got clk=%b phase=%0d expected 1011 %0d", j, clkout, phase, j + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_patterns();
        test_shadow_update();
        test_phase_shift();
        test_watchdog();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
